// File: rtl/k_fifo_ctrl_if.sv
// Handshake and RAM address bundle between a FIFO controller and its producer/consumer.
// The master side offers and takes words; the slave side is the controller.
interface k_fifo_ctrl_if #(
  parameter int addr_bits = 1
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 wen;
  logic [addr_bits-1:0] waddr;
  logic [addr_bits-1:0] raddr;

  modport master (
    output wr_valid, rd_ready,
    input  wr_ready, rd_valid, wen, waddr, raddr
  );

  modport slave (
    input  wr_valid, rd_ready,
    output wr_ready, rd_valid, wen, waddr, raddr
  );
endinterface

// File: rtl/k_fifo_ctrl.sv
// Pointer/occupancy controller for a dual-port FIFO RAM with combinational read path.
// Define K_FIFO_CTRL_ERR_EN to build the sticky overflow/underflow error flags.
module k_fifo_ctrl #(
  parameter int addr_bits = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  k_fifo_ctrl_if.slave       bus,
  output logic [addr_bits:0] count,
  output logic               full,
  output logic               empty,
  input  logic               err_clr,
  output logic               ovf_err,
  output logic               udf_err
);
  localparam logic [addr_bits:0] depth = {1'b1, {addr_bits{1'b0}}};

  logic [addr_bits-1:0] wptr;
  logic [addr_bits-1:0] rptr;
  logic                 push;
  logic                 pop;

  assign full  = (count == depth);
  assign empty = (count == '0);

  // Handshakes depend only on registered occupancy, so wr_valid never reaches rd_valid.
  assign bus.wr_ready = rst_n & ~full;
  assign bus.rd_valid = rst_n & ~empty;
  assign push         = bus.wr_valid & bus.wr_ready;
  assign pop          = bus.rd_valid & bus.rd_ready;
  assign bus.wen      = push;
  assign bus.waddr    = wptr;
  assign bus.raddr    = rptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + addr_bits'(1);
      if (pop)  rptr <= rptr + addr_bits'(1);
      case ({push, pop})
        2'b10:   count <= count + (addr_bits+1)'(1);
        2'b01:   count <= count - (addr_bits+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef K_FIFO_CTRL_ERR_EN
  // A new error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (bus.wr_valid && full) ovf_err <= 1'b1;
      else if (err_clr)         ovf_err <= 1'b0;
      if (bus.rd_ready && empty) udf_err <= 1'b1;
      else if (err_clr)          udf_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign udf_err        = 1'b0;
`endif
endmodule

// File: tb/tb_k_fifo_ctrl.sv
// Self-checking bench for k_fifo_ctrl: a behavioural RAM plus a data scoreboard queue.
module tb_k_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       err_clr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       udf_err;
  logic [7:0] wdata;
  logic [7:0] mem [2];
  logic [7:0] expQ [$];
  int         checks   = 0;
  int         failures = 0;
  int         wp;
  int         rp;

`ifdef K_FIFO_CTRL_ERR_EN
  localparam int errEn = 1;
`else
  localparam int errEn = 0;
`endif

  always #5 clk = ~clk;

  k_fifo_ctrl_if #(.addr_bits(1)) bus ();

  k_fifo_ctrl #(.addr_bits(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .err_clr (err_clr),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rs, input logic wv, input logic [7:0] d,
                               input logic rr, input logic clr);
    rst_n        = rs;
    bus.wr_valid = wv;
    wdata        = d;
    bus.rd_ready = rr;
    err_clr      = clr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Written words queue up in order; every pop must return the oldest one from the RAM model.
  always @(posedge clk) begin
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (bus.rd_valid && bus.rd_ready) begin
        checkOutput("sb_nonempty_on_pop", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0)
          checkOutput("rdata", 32'(mem[bus.raddr]), 32'(expQ.pop_front()));
      end
      if (bus.wen) begin
        mem[bus.waddr] <= wdata;
        expQ.push_back(wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with a pending write
    applyStimulus(0, 1, 8'h99, 0, 0);
    checkOutput("rst_wen", 32'(bus.wen), 0);
    checkOutput("rst_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 0);
    tick();
    checkOutput("rst_wen2", 32'(bus.wen), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_waddr", 32'(bus.waddr), 0);
    checkOutput("rst_raddr", 32'(bus.raddr), 0);
    checkOutput("rst_ovf", 32'(ovf_err), 0);
    checkOutput("rst_udf", 32'(udf_err), 0);

    // Fill with two words
    applyStimulus(1, 1, 8'hA5, 0, 0);
    checkOutput("fill0_wen", 32'(bus.wen), 1);
    checkOutput("fill0_waddr", 32'(bus.waddr), 0);
    tick();
    applyStimulus(1, 1, 8'h3C, 0, 0);
    checkOutput("fill1_wen", 32'(bus.wen), 1);
    checkOutput("fill1_waddr", 32'(bus.waddr), 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("full_count", 32'(count), 2);
    checkOutput("full_wr_ready", 32'(bus.wr_ready), 0);
    checkOutput("full_rd_valid", 32'(bus.rd_valid), 1);

    // Pop from full while a write is held: no push that cycle
    applyStimulus(1, 1, 8'h77, 1, 0);
    checkOutput("fullpop_wen", 32'(bus.wen), 0);
    checkOutput("fullpop_raddr", 32'(bus.raddr), 0);
    tick();
    applyStimulus(1, 1, 8'h77, 0, 0);
    checkOutput("afterpop_count", 32'(count), 1);
    checkOutput("afterpop_raddr", 32'(bus.raddr), 1);
    checkOutput("held_wen", 32'(bus.wen), 1);
    checkOutput("held_waddr_wrap", 32'(bus.waddr), 0);
    tick();
    applyStimulus(1, 0, 8'h00, 1, 0);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("one_count", 32'(count), 1);
    checkOutput("one_raddr", 32'(bus.raddr), 0);
    checkOutput("one_waddr", 32'(bus.waddr), 1);

    // Streaming push+pop at count 1
    wp = 1;
    rp = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 8'(8'h10 + i), 1, 0);
      checkOutput("stream_count", 32'(count), 1);
      checkOutput("stream_wen", 32'(bus.wen), 1);
      checkOutput("stream_waddr", 32'(bus.waddr), 32'(wp));
      checkOutput("stream_raddr", 32'(bus.raddr), 32'(rp));
      tick();
      wp = wp ^ 1;
      rp = rp ^ 1;
    end
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("stream_end_count", 32'(count), 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("drain_empty", 32'(empty), 1);

    // Write into empty with reader ready: readable only next cycle
    applyStimulus(1, 1, 8'hC3, 1, 0);
    checkOutput("empty_push_rd_valid", 32'(bus.rd_valid), 0);
    checkOutput("empty_push_wen", 32'(bus.wen), 1);
    tick();
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("next_rd_valid", 32'(bus.rd_valid), 1);
    checkOutput("next_count", 32'(count), 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("single_count", 32'(count), 0);
    checkOutput("single_empty", 32'(empty), 1);

    // Sticky error flags
    applyStimulus(1, 0, 8'h00, 0, 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("clr0_ovf", 32'(ovf_err), 0);
    checkOutput("clr0_udf", 32'(udf_err), 0);
    applyStimulus(1, 1, 8'h51, 0, 0);
    tick();
    applyStimulus(1, 1, 8'h52, 0, 0);
    tick();
    applyStimulus(1, 1, 8'h53, 0, 0);
    checkOutput("ovf_attempt_wen", 32'(bus.wen), 0);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("ovf_set", 32'(ovf_err), 32'(errEn));
    checkOutput("ovf_full", 32'(full), 1);
    tick();
    checkOutput("ovf_sticky", 32'(ovf_err), 32'(errEn));
    applyStimulus(1, 0, 8'h00, 1, 0);
    tick();
    tick();
    checkOutput("udf_pre", 32'(udf_err), 0);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("udf_set", 32'(udf_err), 32'(errEn));
    applyStimulus(1, 0, 8'h00, 1, 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("udf_set_wins", 32'(udf_err), 32'(errEn));
    checkOutput("ovf_cleared", 32'(ovf_err), 0);
    applyStimulus(1, 0, 8'h00, 0, 1);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("clr_ovf", 32'(ovf_err), 0);
    checkOutput("clr_udf", 32'(udf_err), 0);

    // Reset mid-operation discards contents
    applyStimulus(1, 1, 8'h66, 0, 0);
    tick();
    applyStimulus(0, 1, 8'h67, 0, 0);
    checkOutput("midrst_wen", 32'(bus.wen), 0);
    checkOutput("midrst_wr_ready", 32'(bus.wr_ready), 0);
    tick();
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("midrst_count", 32'(count), 0);
    checkOutput("midrst_empty", 32'(empty), 1);
    checkOutput("midrst_waddr", 32'(bus.waddr), 0);
    checkOutput("midrst_raddr", 32'(bus.raddr), 0);
    checkOutput("midrst_rd_valid", 32'(bus.rd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/k_fifo_ctrl.md
# k_fifo_ctrl

Pointer and flag controller that sits directly upstream of the team's dual-port FIFO RAM and drives its `wen`, `waddr` and `raddr` inputs. It turns a valid/ready write port and a valid/ready read port into RAM write strobes and addresses, and tracks occupancy. The RAM read path is combinational, so the data at the selected `raddr` is valid in the same cycle `rd_valid` is high. With the default parameter it drives the 2-entry RAM used in the FIFO datapath.

## Interface

- `addr_bits`, 1: pointer width; depth = 2**addr_bits (default 2 entries).
- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `wr_valid` input 1: producer offers a word this cycle.
- `wr_ready` output 1: controller accepts a word this cycle.
- `rd_valid` output 1: the RAM word at `raddr` is valid.
- `rd_ready` input 1: consumer takes the word this cycle.
- `wen` output 1: RAM write enable.
- `waddr` output addr_bits: RAM write address (write pointer).
- `raddr` output addr_bits: RAM read address (read pointer).
- `count` output addr_bits+1: current occupancy, 0..depth.
- `full` output 1: count == depth.
- `empty` output 1: count == 0.
- `err_clr` input 1: clears the sticky error flags.
- `ovf_err` output 1: sticky; set on a push attempt while full.
- `udf_err` output 1: sticky; set on a pop attempt while empty.

## Operation

- State registers: `wptr`, `rptr` (addr_bits each) and `count` (addr_bits+1).
- `waddr` = `wptr`. `raddr` = `rptr`.
- `full` and `empty` are decoded from the registered `count`.
- `wr_ready` = `rst_n` & !full. `rd_valid` = `rst_n` & !empty.
- push = `wr_valid` & `wr_ready`. `wen` = push.
- pop = `rd_valid` & `rd_ready`.
- On push, `wptr` increments modulo depth. On pop, `rptr` increments modulo depth. Both pointers wrap naturally from depth-1 to 0.
- `count` next value:
  - +1 on push only.
  - -1 on pop only.
  - unchanged when both or neither occur.
- Simultaneous push and pop:
  - Allowed only when 0 < count < depth.
  - Count is unchanged and both pointers advance.
  - When full, `wr_ready` is low, so there is no push even if a pop happens the same cycle. There is no same-cycle bypass.
  - When empty, `rd_valid` is low, so a word written this cycle is not readable until the next cycle.
- The producer may hold `wr_valid` while `wr_ready` is low. The word is taken on the first cycle both are high.

## Timing

- Reset values (the cycle after `rst_n` is sampled low):
  - `wptr` = 0, `rptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `ovf_err` = 0, `udf_err` = 0.
- While `rst_n` is low, `wr_ready`, `rd_valid` and `wen` are forced to 0 combinationally.
- Reset mid-operation discards all contents. Pointers return to 0 and no write occurs in the reset cycle.
- Push-to-read latency is 1 cycle:
  - A word written at edge N has `rd_valid` high and is addressed by `raddr` after edge N.
  - The RAM updates at the same edge, so the data is visible in that cycle.
- `wen`, `wr_ready` and `rd_valid` are combinational from registered state and the handshake inputs. There is no combinational path from `wr_valid` to `rd_valid`.
- Sustained throughput is 1 word per cycle when the FIFO is neither empty nor full.

## Configuration

- Macro: `K_FIFO_CTRL_ERR_EN`.
- Defined:
  - `ovf_err` sets at an edge where `wr_valid` & full & `rst_n`.
  - `udf_err` sets at an edge where `rd_ready` & empty & `rst_n`.
  - Both hold until `err_clr` = 1 or reset.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- Not defined: `ovf_err` and `udf_err` are tied to 0, `err_clr` is ignored, and no error registers exist.

## Test plan

- Reset with `wr_valid` = 1 and `rst_n` = 0 -> `wen` = 0, `count` = 0, `empty` = 1, `waddr` = `raddr` = 0.
- Push 0xA5 then 0x3C with `rd_ready` = 0 -> `wen` high for 2 cycles with `waddr` 0 then 1. Then `full` = 1, `count` = 2, `wr_ready` = 0.
- From full, hold `wr_valid` = 1 and `rd_ready` = 1 for one cycle -> exactly one pop and no push. `count` = 1, `raddr` advances 0→1, and the push lands next cycle at `waddr` = 0 (wrap).
- With count = 1, assert push and pop continuously for 6 cycles -> `count` stays 1, both pointers toggle every cycle, and read data order matches write order.
- Empty FIFO, single push with `rd_ready` = 1 -> `rd_valid` is 0 in the push cycle and 1 in the next. The pop then returns `count` to 0.
- With `K_FIFO_CTRL_ERR_EN` defined:
  - Push attempt when full -> `ovf_err` = 1 and stays set.
  - `rd_ready` when empty -> `udf_err` = 1.
  - `err_clr` pulse -> both 0 next cycle.
- Without the macro, the same stimulus leaves both flags at 0.
